// File: rtl/adc_scan_seq.sv
// adc_scan_seq -- ADC channel scan sequencer with a tagged result FIFO.
//
// Walks the enabled channels in cfg_ch_mask from lowest to highest. For each
// channel it selects the mux, waits cfg_settle cycles and performs a
// req/ack conversion handshake with the ADC core. Each result is tagged with
// its channel number and pushed into a show-ahead FIFO that the CPU pops.
//
// Ports:
//   clk, arst_n          clock, asynchronous active-low reset
//   cfg_ch_mask          channel enable mask (latched at scan start)
//   cfg_settle           settle cycles after a mux change (latched at scan start)
//   cfg_continuous       restart from channel 0 after the last enabled channel
//   start                level; a rising edge launches a scan from IDLE
//   abort                synchronous abort of a running scan
//   adc_ch_sel           ADC mux select
//   adc_conv_req         conversion request, held until adc_conv_ack
//   adc_conv_ack         1-cycle ack qualifying adc_data
//   adc_data             conversion result
//   res_valid/res_ready  FIFO not-empty / pop
//   res_data             {channel[3:0], sample}, FIFO head
//   busy                 sequencer not idle
//   done_pulse           1 cycle at end of a single scan, after abort, or on
//                        a start with an empty mask
//   ovf, ovf_clr         sticky result-dropped flag and its clear
//
// Optional feature: define ADC_SEQ_AVG_EN to run four conversions per channel
// and store the rounded average (settle only before the first conversion).
// FIFO_DEPTH must be a power of two and at least 2.

module adc_scan_seq #(
  parameter int NUM_CH     = 8,
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic [NUM_CH-1:0]         cfg_ch_mask,
  input  logic [7:0]                cfg_settle,
  input  logic                      cfg_continuous,
  input  logic                      start,
  input  logic                      abort,
  output logic [$clog2(NUM_CH)-1:0] adc_ch_sel,
  output logic                      adc_conv_req,
  input  logic                      adc_conv_ack,
  input  logic [DATA_W-1:0]         adc_data,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [4+DATA_W-1:0]       res_data,
  output logic                      busy,
  output logic                      done_pulse,
  output logic                      ovf,
  input  logic                      ovf_clr
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = CH_W + 1;          // ptr can reach NUM_CH (past the last channel)
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int RES_W = 4 + DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_SETTLE,
    S_CONV,
    S_STORE
  } state_t;

  state_t state, state_nx;

  logic              start_q;
  logic              start_rise;
  logic [NUM_CH-1:0] mask_l;
  logic [7:0]        settle_l;
  logic [PTR_W-1:0]  ptr;
  logic [7:0]        settle_cnt;
  logic [DATA_W-1:0] sample;
  logic [DATA_W-1:0] sample_nx;
  logic              last_conv;
  logic              done_nx;
  logic              found;
  logic [CH_W-1:0]   found_ch;

  // FIFO
  logic [RES_W-1:0]  mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              empty, full, push, pop, store, drop;

  assign start_rise = start & ~start_q;

  // Lowest enabled channel at or above ptr.
  always_comb begin
    found    = 1'b0;
    found_ch = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!found && mask_l[i] && (PTR_W'(i) >= ptr)) begin
        found    = 1'b1;
        found_ch = CH_W'(i);
      end
    end
  end

`ifdef ADC_SEQ_AVG_EN
  logic [1:0]        conv_idx;
  logic [DATA_W+1:0] acc;
  logic [DATA_W+1:0] acc_sum;

  always_comb begin
    acc_sum   = acc + (DATA_W+2)'(adc_data);
    last_conv = (conv_idx == 2'd3);
    // Four samples summed in DATA_W+2 bits; +2 rounds the divide by 4.
    sample_nx = DATA_W'((acc_sum + (DATA_W+2)'(2)) >> 2);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      conv_idx <= '0;
      acc      <= '0;
    end else if (state == S_SCAN) begin
      conv_idx <= '0;
      acc      <= '0;
    end else if (state == S_CONV && adc_conv_ack) begin
      conv_idx <= conv_idx + 2'd1;
      acc      <= acc_sum;
    end
  end
`else
  always_comb begin
    last_conv = 1'b1;
    sample_nx = adc_data;
  end
`endif

  // Next-state logic
  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_rise) begin
          if (cfg_ch_mask != '0) state_nx = S_SCAN;
          else                   done_nx  = 1'b1;
        end
      end
      S_SCAN: begin
        if (found)               state_nx = S_SETTLE;
        else if (cfg_continuous) state_nx = S_SCAN;
        else begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == settle_l) state_nx = S_CONV;
      end
      S_CONV: begin
        if (adc_conv_ack) state_nx = last_conv ? S_STORE : S_CONV;
      end
      S_STORE: state_nx = S_SCAN;
      default: state_nx = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) begin
      state_nx = S_IDLE;
      done_nx  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= S_IDLE;
      start_q    <= 1'b0;
      mask_l     <= '0;
      settle_l   <= '0;
      ptr        <= '0;
      settle_cnt <= '0;
      adc_ch_sel <= '0;
      sample     <= '0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_nx;
      start_q    <= start;
      done_pulse <= done_nx;
      case (state)
        S_IDLE: begin
          if (start_rise) begin
            mask_l   <= cfg_ch_mask;
            settle_l <= cfg_settle;
            ptr      <= '0;
          end
        end
        S_SCAN: begin
          if (found) begin
            adc_ch_sel <= found_ch;
            settle_cnt <= '0;
          end else begin
            ptr <= '0;
          end
        end
        S_SETTLE: settle_cnt <= settle_cnt + 8'd1;
        S_CONV: begin
          if (adc_conv_ack && last_conv) sample <= sample_nx;
        end
        S_STORE: ptr <= PTR_W'(adc_ch_sel) + PTR_W'(1);
        default: ;
      endcase
    end
  end

  // Result FIFO: a push onto a full FIFO is accepted when a pop frees a slot
  // in the same cycle, otherwise the result is dropped and ovf is set.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = ~empty & res_ready;
  assign store = (state == S_STORE) & ~abort;
  assign push  = store & (~full | pop);
  assign drop  = store & full & ~pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {4'(adc_ch_sel), sample};
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  assign res_valid    = ~empty;
  assign res_data     = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign busy         = (state != S_IDLE);
  assign adc_conv_req = (state == S_CONV);

endmodule

// File: tb/tb_adc_scan_seq.sv
module tb_adc_scan_seq;
  localparam int NUM_CH     = 8;
  localparam int DATA_W     = 12;
  localparam int FIFO_DEPTH = 8;
`ifdef ADC_SEQ_AVG_EN
  localparam int N_CONV = 4;
`else
  localparam int N_CONV = 1;
`endif

  logic              clk = 1'b0;
  logic              arst_n = 1'b0;
  logic [7:0]        cfg_ch_mask = '0;
  logic [7:0]        cfg_settle = '0;
  logic              cfg_continuous = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [2:0]        adc_ch_sel;
  logic              adc_conv_req;
  logic              adc_conv_ack = 1'b0;
  logic [11:0]       adc_data = '0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [15:0]       res_data;
  logic              busy;
  logic              done_pulse;
  logic              ovf;
  logic              ovf_clr = 1'b0;

  adc_scan_seq #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .arst_n(arst_n), .cfg_ch_mask(cfg_ch_mask), .cfg_settle(cfg_settle),
    .cfg_continuous(cfg_continuous), .start(start), .abort(abort),
    .adc_ch_sel(adc_ch_sel), .adc_conv_req(adc_conv_req), .adc_conv_ack(adc_conv_ack),
    .adc_data(adc_data), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .done_pulse(done_pulse), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int rdy_mode = 0;        // 0 ready low, 1 ready high, 2 random, 3 driven by hand
  bit chk_en = 1'b0;

  // Reference model state
  logic [15:0] mq[$];      // expected FIFO contents, head first
  logic        m_ovf;
  logic        accept = 1'b0;  // the ack being driven is one the sequencer must take
  int          exp_ch = 0;
  logic [11:0] forced[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one result per channel, appearing one cycle after its final ack;
  // pop before push so a full FIFO with a pop accepts the new result.
  initial begin : model
    bit          drop;
    bit          pend;
    logic [15:0] pend_word;
    int          acc, nacc;
    pend = 0; pend_word = '0; acc = 0; nacc = 0; m_ovf = 1'b0;
    forever begin
      @(posedge clk or negedge arst_n);
      if (!arst_n) begin
        mq.delete();
        m_ovf = 1'b0; pend = 0; acc = 0; nacc = 0;
      end else begin
        if (mq.size() != 0 && res_ready) void'(mq.pop_front());
        drop = 0;
        if (pend) begin
          if (mq.size() >= FIFO_DEPTH) drop = 1;
          else mq.push_back(pend_word);
        end
        if (drop) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
        pend = 0;
        if (adc_conv_ack && accept) begin
          acc += int'(adc_data);
          nacc++;
          if (nacc == N_CONV) begin
            pend      = 1;
            pend_word = {4'(exp_ch), 12'((acc + N_CONV / 2) / N_CONV)};
            acc = 0; nacc = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison of the result interface against the model.
  initial forever begin
    @(negedge clk);
    if (arst_n && chk_en) begin
      check("res_valid", res_valid, mq.size() != 0);
      if (mq.size() != 0) check("res_data", res_data, mq[0]);
      check("ovf", ovf, m_ovf);
    end
  end

  initial forever begin
    @(negedge clk);
    if (done_pulse) done_cnt++;
  end

  initial forever begin
    @(negedge clk);
    case (rdy_mode)
      0: res_ready = 1'b0;
      1: res_ready = 1'b1;
      2: res_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  task automatic wait_req(output int k);
    k = 0;
    while (adc_conv_req !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (adc_conv_req !== 1'b1) check("req_timeout", adc_conv_req, 1);
  endtask

  // Called at a negedge with adc_conv_req visible; returns at the negedge
  // after the result has been stored (or dropped).
  task automatic do_conv(input int ch, input int dmin, input int dmax,
                         input bit pop_store, input bit clr_store);
    for (int r = 0; r < N_CONV; r++) begin
      int d;
      d = $urandom_range(dmax, dmin);
      repeat (d) begin
        @(negedge clk);
        check("req_hold", adc_conv_req, 1);
      end
      adc_conv_ack = 1'b1;
      adc_data     = (forced.size() != 0) ? forced.pop_front() : 12'($urandom);
      accept       = 1'b1;
      exp_ch       = ch;
      @(negedge clk);
      adc_conv_ack = 1'b0;
      accept       = 1'b0;
    end
    if (pop_store) res_ready = 1'b1;
    if (clr_store) ovf_clr = 1'b1;
    @(negedge clk);
    if (pop_store) res_ready = 1'b0;
    if (clr_store) ovf_clr = 1'b0;
  endtask

  task automatic run_scan(input logic [7:0] mask, input logic [7:0] settle,
                          input int dmin, input int dmax, input bit scramble);
    int k, d0;
    int chs[$];
    for (int c = 0; c < NUM_CH; c++) if (mask[c]) chs.push_back(c);
    cfg_ch_mask = mask; cfg_settle = settle; cfg_continuous = 1'b0;
    @(negedge clk);
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    if (scramble) begin
      cfg_ch_mask = 8'($urandom);
      cfg_settle  = 8'($urandom_range(0, 20));
    end
    foreach (chs[j]) begin
      wait_req(k);
      if (j == 0) check("start_to_req", k, 2 + int'(settle));
      check("ch_sel", adc_ch_sel, chs[j]);
      do_conv(chs[j], dmin, dmax, 1'b0, 1'b0);
    end
    @(negedge clk);
    check("done_end", done_pulse, 1);
    check("busy_end", busy, 0);
    @(negedge clk);
    check("done_once", done_pulse, 0);
    check("done_count", done_cnt - d0, 1);
    check("req_idle", adc_conv_req, 0);
  endtask

  task automatic drain();
    rdy_mode = 1;
    for (int i = 0; i < 40 && mq.size() != 0; i++) @(negedge clk);
    rdy_mode = 0;
    @(negedge clk);
    check("drained", res_valid, 0);
  endtask

  initial begin : watchdog
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : main
    int k;
    int exp_t1[3];
    exp_t1 = '{2, 5, 7};

    // Reset values
    @(negedge clk);
    #2;
    check("rst_busy", busy, 0);
    check("rst_req", adc_conv_req, 0);
    check("rst_valid", res_valid, 0);
    check("rst_data", res_data, 0);
    check("rst_done", done_pulse, 0);
    check("rst_ovf", ovf, 0);
    check("rst_chsel", adc_ch_sel, 0);
    arst_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // T1: three channels, settle 3, ack 5 cycles after req
    rdy_mode = 0;
    run_scan(8'b1010_0100, 8'd3, 5, 5, 1'b0);
    check("t1_count", mq.size(), 3);
    rdy_mode = 3;
    res_ready = 1'b0;
    @(negedge clk);
    foreach (exp_t1[i]) begin
      check("t1_order", res_data[15:12], exp_t1[i]);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
    end
    check("t1_empty", res_valid, 0);

    // T4: start with an empty mask, plus a stray ack while idle
    cfg_ch_mask = 8'h00;
    @(negedge clk);
    start = 1'b1;
    adc_conv_ack = 1'b1; adc_data = 12'hABC; accept = 1'b0;
    @(negedge clk);
    start = 1'b0; adc_conv_ack = 1'b0;
    check("t4_done", done_pulse, 1);
    check("t4_busy", busy, 0);
    check("t4_req", adc_conv_req, 0);
    @(negedge clk);
    check("t4_done_once", done_pulse, 0);
    repeat (3) begin
      @(negedge clk);
      check("t4_no_req", adc_conv_req, 0);
    end

    // Boundaries: settle 0, single ch0, all channels with CSR changes mid-scan
    rdy_mode = 1;
    run_scan(8'h01, 8'd0, 0, 0, 1'b0);
    run_scan(8'hFF, 8'd1, 0, 2, 1'b1);
    run_scan(8'h80, 8'd0, 1, 3, 1'b0);

    // Randomized single scans
    for (int it = 0; it < 20; it++) begin
      logic [7:0] m;
      m = 8'($urandom_range(1, 255));
      rdy_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) begin
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
      end
      run_scan(m, 8'($urandom_range(0, 4)), 0, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    // T2: continuous ch7 with ready low fills the FIFO, ninth result overflows
    drain();
    rdy_mode = 3;
    res_ready = 1'b0;
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    cfg_ch_mask = 8'h80; cfg_settle = 8'd1; cfg_continuous = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wait_req(k);
      check("t2_ch", adc_ch_sel, 7);
      do_conv(7, 0, 2, 1'b0, i == 8);   // clear coincides with the drop on the ninth
      if (i == 7) begin
        check("t2_full_cnt", mq.size(), 8);
        check("t2_full_valid", res_valid, 1);
        check("t2_no_ovf_yet", ovf, 0);
      end
    end
    check("t2_ovf_set_wins", ovf, 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("t2_ovf_cleared", ovf, 0);

    // T5: full FIFO popped on the store cycle keeps the result
    wait_req(k);
    do_conv(7, 0, 2, 1'b1, 1'b0);
    check("t5_no_ovf", ovf, 0);
    check("t5_count", mq.size(), 8);

    // T3: abort during CONV, late ack ignored, FIFO kept
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    wait_req(k);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t3_req_drop", adc_conv_req, 0);
    check("t3_done", done_pulse, 1);
    check("t3_busy", busy, 0);
    adc_conv_ack = 1'b1; adc_data = 12'h5A5; accept = 1'b0;
    @(negedge clk);
    adc_conv_ack = 1'b0;
    check("t3_done_once", done_pulse, 0);
    repeat (3) @(negedge clk);
    check("t3_fifo_kept", mq.size(), 6);
    check("t3_valid", res_valid, 1);
    cfg_continuous = 1'b0;
    drain();

    // Asynchronous reset in the middle of a scan flushes everything
    rdy_mode = 0;
    cfg_ch_mask = 8'h3C; cfg_settle = 8'd0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_req(k);
    do_conv(2, 0, 1, 1'b0, 1'b0);
    wait_req(k);
    #2 arst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_req", adc_conv_req, 0);
    check("arst_valid", res_valid, 0);
    check("arst_chsel", adc_ch_sel, 0);
    check("arst_ovf", ovf, 0);
    @(negedge clk);
    #2 arst_n = 1'b1;
    @(negedge clk);
    check("arst_idle", busy, 0);
    run_scan(8'h11, 8'd2, 0, 3, 1'b0);

`ifdef ADC_SEQ_AVG_EN
    // T6: averaging of four conversions with rounding
    drain();
    forced.push_back(12'd100);
    forced.push_back(12'd101);
    forced.push_back(12'd102);
    forced.push_back(12'd104);
    run_scan(8'h01, 8'd0, 0, 1, 1'b0);
    check("t6_avg", res_data[11:0], 102);
    check("t6_ch", res_data[15:12], 0);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
